md_unit_iter: RTL and testbench

//  Parametrised multiply/divide unit for the EX stage of the pipelined MIPS core; holds HI/LO.

---
 rtl/md_unit_iter.sv | 192 +++++++++++++++++++
 tb/tb_md_unit_iter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/md_unit_iter.sv
// Multiply/divide unit with HI/LO for the EX stage: fixed-latency multiply/MAC,
// radix-2 restoring divider, busy/done handshake and flush.
module md_unit_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   hi_q, lo_q, quo, rem, dvs;
    logic               q_neg, r_neg, div_zero, done_q;

    logic op_mul, op_div, op_signed, op_add, op_sub;
    logic load_mul, load_div, wr_hi, wr_lo, fin_mul, fin_div, div_step, cnt_dec;

    logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_val;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs, q_fix, r_fix;
    logic [WIDTH:0]     r_sh, diff;

    always_comb begin
        op_mul    = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
        op_div    = op inside {OP_DIV, OP_DIVU};
        op_signed = op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
        op_add    = op inside {OP_MADD, OP_MADDU};
        op_sub    = op inside {OP_MSUB, OP_MSUBU};
    end

    // The final HI:LO value is computed at the start edge and held until the latency expires.
    assign a_ext = {{WIDTH{op_signed & rs_val[WIDTH-1]}}, rs_val};
    assign b_ext = {{WIDTH{op_signed & rt_val[WIDTH-1]}}, rt_val};
    assign prod  = a_ext * b_ext;

    always_comb begin
        mul_val = prod;
        if (op_add)
            mul_val = {hi_q, lo_q} + prod;
        else if (op_sub)
            mul_val = {hi_q, lo_q} - prod;
    end

    assign a_neg = op_signed & rs_val[WIDTH-1];
    assign b_neg = op_signed & rt_val[WIDTH-1];
    assign a_abs = a_neg ? -rs_val : rs_val;
    assign b_abs = b_neg ? -rt_val : rt_val;

    assign r_sh  = {rem, quo[WIDTH-1]};
    assign diff  = r_sh - {1'b0, dvs};
    assign q_fix = div_zero ? '1 : (q_neg ? -quo : quo);
    assign r_fix = r_neg ? -rem : rem;

    always_comb begin
        state_nx = state;
        load_mul = 1'b0;
        load_div = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        fin_mul  = 1'b0;
        fin_div  = 1'b0;
        div_step = 1'b0;
        cnt_dec  = 1'b0;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op_mul) begin
                            state_nx = S_MUL;
                            load_mul = 1'b1;
                        end else if (op_div) begin
                            state_nx = S_DIV;
                            load_div = 1'b1;
                        end else if (op == OP_MTHI) begin
                            wr_hi = 1'b1;
                        end else if (op == OP_MTLO) begin
                            wr_lo = 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        state_nx = S_IDLE;
                        fin_mul  = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_DIV: begin
                    div_step = 1'b1;
                    if (cnt == '0)
                        state_nx = S_FIX;
                    else
                        cnt_dec = 1'b1;
                end
                S_FIX: begin
                    state_nx = S_IDLE;
                    fin_div  = 1'b1;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            mul_res  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= fin_mul | fin_div;
            if (load_mul) begin
                mul_res <= mul_val;
                cnt     <= CW'(MUL_LAT - 1);
            end
            if (load_div) begin
                quo      <= a_abs;
                rem      <= '0;
                dvs      <= b_abs;
                q_neg    <= a_neg ^ b_neg;
                r_neg    <= a_neg;
                div_zero <= (rt_val == '0);
                cnt      <= CW'(WIDTH - 1);
            end
            if (cnt_dec)
                cnt <= cnt - CW'(1);
            // Restoring step: keep the trial difference only when it did not borrow.
            if (div_step) begin
                quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                rem <= diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            end
            if (wr_hi)
                hi_q <= rs_val;
            if (wr_lo)
                lo_q <= rs_val;
            if (fin_mul)
                {hi_q, lo_q} <= mul_res;
            if (fin_div) begin
                hi_q <= r_fix;
                lo_q <= q_fix;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_md_unit_iter.sv
// Directed self-checking bench for md_unit_iter at WIDTH=32, MUL_LAT=5.
module tb_md_unit_iter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [3:0]   op;
    logic [W-1:0] rs_val, rt_val;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    int           n_checks = 0;
    int           n_pass = 0;
    logic         saw;

    md_unit_iter #(.WIDTH(W), .MUL_LAT(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Counts busy cycles from the start edge; leaves time positioned in the done cycle.
    task automatic wait_fin(input string tag, input int pre, input int n,
                            input logic [W-1:0] eh, input logic [W-1:0] el);
        int cyc = pre;
        while (busy === 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({tag, " cycles"}, 64'(cyc), 64'(n));
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        op = '0; rs_val = '0; rt_val = '0;
        #12;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        go(4'd0, 32'hffff0000, 32'd2);
        wait_fin("mult", 0, 5, 32'hffffffff, 32'hfffe0000);
        tick();
        chk("mult done drop", 64'(done), 64'd0);

        go(4'd1, 32'hffff0000, 32'd2);
        wait_fin("multu", 0, 5, 32'h00000001, 32'hfffe0000);
        tick();
        go(4'd2, 32'hffff0000, 32'd2);
        wait_fin("div", 0, 33, 32'h0, 32'hffff8000);
        tick();
        go(4'd3, 32'hffff0000, 32'd2);
        wait_fin("divu", 0, 33, 32'h0, 32'h7fff8000);
        tick();
        go(4'd2, 32'd7, 32'd0);
        wait_fin("div by 0", 0, 33, 32'd7, 32'hffffffff);
        tick();
        go(4'd2, 32'h80000000, 32'hffffffff);
        wait_fin("div min/-1", 0, 33, 32'h0, 32'h80000000);
        tick();
        go(4'd2, 32'd7, 32'hfffffffe);
        wait_fin("div 7/-2", 0, 33, 32'd1, 32'hfffffffd);
        tick();
        go(4'd2, 32'hfffffff9, 32'd2);
        wait_fin("div -7/2", 0, 33, 32'hffffffff, 32'hfffffffd);
        tick();

        go(4'd8, 32'd1, 32'd0);
        chk("mthi hi", 64'(hi), 64'd1);
        chk("mthi busy", 64'(busy), 64'd0);
        go(4'd9, 32'hfffffffe, 32'd0);
        chk("mtlo lo", 64'(lo), 64'hfffffffe);
        chk("mtlo done", 64'(done), 64'd0);

        // 0x1_fffffffe + 1 = 0x1_ffffffff; minus 1 returns to 0x1_fffffffe.
        go(4'd5, 32'd1, 32'd1);
        wait_fin("maddu a", 0, 5, 32'd1, 32'hffffffff);
        tick();
        go(4'd6, 32'd1, 32'd1);
        wait_fin("msub a", 0, 5, 32'd1, 32'hfffffffe);
        tick();

        go(4'd9, 32'hffffffff, 32'd0);
        go(4'd5, 32'd1, 32'd1);
        wait_fin("maddu b", 0, 5, 32'd2, 32'd0);
        go(4'd6, 32'd1, 32'd1);
        chk("b2b busy", 64'(busy), 64'd1);
        chk("b2b done drop", 64'(done), 64'd0);
        wait_fin("msub b2b", 0, 5, 32'd1, 32'hffffffff);
        tick();
        go(4'd7, 32'hffffffff, 32'd2);
        wait_fin("msubu", 0, 5, 32'd0, 32'd1);
        tick();
        go(4'd4, 32'hffffffff, 32'd2);
        wait_fin("madd neg", 0, 5, 32'hffffffff, 32'hffffffff);
        tick();

        go(4'd3, 32'd100, 32'd3);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush done", 64'(done), 64'd0);
        chk("flush hi", 64'(hi), 64'hffffffff);
        chk("flush lo", 64'(lo), 64'hffffffff);
        saw = 1'b0;
        repeat (40) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        chk("flush quiet", 64'(saw), 64'd0);

        op = 4'd8; rs_val = 32'h1234; start = 1'b1; flush = 1'b1;
        tick();
        chk("flush+mthi hi", 64'(hi), 64'hffffffff);
        op = 4'd3; rs_val = 32'd100; rt_val = 32'd3;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush+divu busy", 64'(busy), 64'd0);

        go(4'd10, 32'd55, 32'd66);
        chk("op10 busy", 64'(busy), 64'd0);
        chk("op10 hi", 64'(hi), 64'hffffffff);
        chk("op10 lo", 64'(lo), 64'hffffffff);

        go(4'd3, 32'd100, 32'd3);
        repeat (3) tick();
        op = 4'd0; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        wait_fin("divu ignore", 4, 33, 32'd1, 32'd33);
        tick();
        chk("ignored mult busy", 64'(busy), 64'd0);
        chk("ignored mult done", 64'(done), 64'd0);

        go(4'd2, 32'hffff0000, 32'd2);
        repeat (5) tick();
        reset = 1'b0;
        #1;
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst hi", 64'(hi), 64'd0);
        chk("async rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post rst busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
